reg_bank_arbiter: RTL and testbench
===================================

Name: reg_bank_arbiter

Overview:
- Two-port access controller in front of the single-port register_bank.
- Accepts independent read/write requests from two requesters (port 0: instruction/control path, port 1: secondary master such as debug or DMA).
- Arbitrates round-robin and drives the bank's CS / RD_WR / address / shared tri-state data bus with exactly one access at a time.
- Returns read data and a one-cycle acknowledge to the winning requester; flags out-of-range addresses without touching the bank.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (8): data bus width.
- ADDR_WIDTH, 3: register address width.
- NUM_REG, 8: number of implemented registers; valid addresses 0..NUM_REG-1, NUM_REG <= 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-low reset.
- req0 / req1  input  1  request from port 0 / 1; held high until ack.
- we0 / we1  input  1  1 = write, 0 = read; stable while req high.
- addr0 / addr1  input  ADDR_WIDTH  register address; stable while req high.
- wdata0 / wdata1  input  DATA_WIDTH  write data; stable while req high.
- ack0 / ack1  output  1  one-cycle completion pulse.
- err0 / err1  output  1  valid with ack; 1 = address >= NUM_REG, no bank access.
- rdata0 / rdata1  output  DATA_WIDTH  read result; valid with ack on a read, held until that port's next ack.
- bank_cs  output  1  to register_bank CS.
- bank_rd_wr  output  1  to register_bank RD_WR (1 = read, 0 = write).
- bank_addr  output  ADDR_WIDTH  to register_bank address.
- bank_data  inout  DATA_WIDTH  shared data bus to register_bank.

Behaviour:
- Reset (reset=0 at posedge): state=IDLE; bank_cs=0, bank_rd_wr=1, bank_addr=0, bank_data=Z; ack0/1=0, err0/1=0, rdata0/1=0; last_grant=1, so port 0 wins the first tie.
- Reset mid-transaction: abort to IDLE on that edge; no ack is issued. A write whose ACCESS edge coincides with reset low is not guaranteed. Requesters re-issue.
- All bank_* outputs and ack/err/rdata are registered.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the port != last_grant.
  - On grant: latch we/addr/wdata, update last_grant.
  - If addr < NUM_REG: go to ACCESS.
  - Else go directly to RESP with err=1.
  - No req: stay in IDLE.
- ACCESS (exactly 1 cycle): bank_cs=1, bank_addr=latched addr, bank_rd_wr=~we.
  - Write: bank_data driven with latched wdata during this cycle only; the bank captures it on the closing edge.
  - Read: bank_data=Z; the bus value is sampled into the granted port's rdata on the closing edge.
  - Next state: RESP.
- RESP (1 cycle): bank_cs=0, bank_data=Z; ack of the granted port=1; err as determined.
  - On error reads, rdata of that port is set to 0.
  - Next state: IDLE.
- Latency: req seen in IDLE at cycle N -> ack high in cycle N+2 (valid address) or N+1 (invalid address). Maximum throughput is one transaction per 3 cycles.
- Back-to-back: a req still high in the IDLE cycle after ack is treated as a new transaction. Requesters must drop req on the edge after seeing ack if no further access is wanted.
- Fairness: under continuous requests from both ports, grants strictly alternate 0,1,0,1...
- Only one ack is ever high in a cycle; the non-granted port's outputs hold.
- bank_data is never driven outside a write ACCESS cycle. No bus contention with the bank's read drive.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release -> bank_cs=0, bank_data=Z, ack0=ack1=0, rdata0=rdata1=0.
- Single port: port 0 writes 8'hA5 to addr 3 -> one ACCESS cycle with bank_cs=1, bank_rd_wr=0, bank_data=A5; ack0 two cycles after req. Then port 0 reads addr 3 -> ack0 with rdata0=8'hA5.
- Contention: both ports request simultaneously (port 0 write 8'h11 to addr 1, port 1 write 8'h22 to addr 2) from reset -> port 0 acked first, port 1 three cycles later. Readback gives addr1=11, addr2=22.
- Fairness: both ports hold req for 6 transactions -> acks alternate 0,1,0,1,0,1. No cycle has ack0 and ack1 both high.
- Out of range: instantiate with NUM_REG=6; port 1 reads addr 7 -> ack1 with err1=1, rdata1=0, one cycle after req, bank_cs never asserted.
- Reset during ACCESS: assert reset=0 in the ACCESS cycle of a port 0 read -> FSM back in IDLE, no ack0, bank_cs=0 next cycle. After release, the re-issued read completes normally.

Source files
------------

// File: rtl/reg_bank_arbiter.sv
// ============================================================================
// Module   : reg_bank_arbiter
// Purpose  : Two-port round-robin access controller in front of a single-port
//            register bank. Serialises read/write requests from two
//            requesters onto the bank's CS / RD_WR / address / shared
//            tri-state data bus and returns a one-cycle acknowledge, read
//            data and an out-of-range error flag to the winning requester.
// Ports    : clk_i            system clock, rising edge
//            reset_ni         synchronous active-low reset
//            reqN_i / weN_i   request / write-enable from port N (0 or 1)
//            addrN_i          register address from port N
//            wdataN_i         write data from port N
//            ackN_o           one-cycle completion pulse to port N
//            errN_o           with ack: address >= NUM_REG, bank untouched
//            rdataN_o         read result, held until port N's next ack
//            bank_cs_o        bank chip select
//            bank_rd_wr_o     bank direction (1 = read, 0 = write)
//            bank_addr_o      bank register address
//            bank_data_io     shared tri-state data bus
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_bank_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_REG    = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  req0_i,
  input  logic                  req1_i,
  input  logic                  we0_i,
  input  logic                  we1_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  output logic                  ack0_o,
  output logic                  ack1_o,
  output logic                  err0_o,
  output logic                  err1_o,
  output logic [DATA_WIDTH-1:0] rdata0_o,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic                  bank_cs_o,
  output logic                  bank_rd_wr_o,
  output logic [ADDR_WIDTH-1:0] bank_addr_o,
  inout  wire  [DATA_WIDTH-1:0] bank_data_io
);

  // One extra bit so NUM_REG == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] NUM_REG_C = (ADDR_WIDTH+1)'(NUM_REG);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  sel_q, sel_d;
  logic                  we_q, we_d;
  logic                  bank_cs_q, bank_cs_d;
  logic                  bank_rd_wr_q, bank_rd_wr_d;
  logic [ADDR_WIDTH-1:0] bank_addr_q, bank_addr_d;
  logic [DATA_WIDTH-1:0] bank_wdata_q, bank_wdata_d;
  logic                  drive_q, drive_d;
  logic                  ack0_q, ack0_d, ack1_q, ack1_d;
  logic                  err0_q, err0_d, err1_q, err1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  // Round-robin: on a tie the port that did not win last time is chosen.
  logic                  gnt0, gnt1, gnt_any;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  addr_ok;

  assign gnt0      = req0_i & (~req1_i | last_grant_q);
  assign gnt1      = req1_i & (~req0_i | ~last_grant_q);
  assign gnt_any   = gnt0 | gnt1;
  assign req_we    = gnt1 ? we1_i    : we0_i;
  assign req_addr  = gnt1 ? addr1_i  : addr0_i;
  assign req_wdata = gnt1 ? wdata1_i : wdata0_i;
  assign addr_ok   = {1'b0, req_addr} < NUM_REG_C;

  // The bus is only ever driven during a write ACCESS cycle.
  assign bank_data_io = drive_q ? bank_wdata_q : {DATA_WIDTH{1'bz}};

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    we_d         = we_q;
    bank_cs_d    = 1'b0;
    bank_rd_wr_d = 1'b1;
    bank_addr_d  = bank_addr_q;
    bank_wdata_d = bank_wdata_q;
    drive_d      = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    unique case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          sel_d        = gnt1;
          last_grant_d = gnt1;
          we_d         = req_we;
          if (addr_ok) begin
            // Outputs are registered, so the ACCESS-cycle bus values are
            // loaded on the edge that enters ACCESS.
            state_d      = S_ACCESS;
            bank_cs_d    = 1'b1;
            bank_rd_wr_d = ~req_we;
            bank_addr_d  = req_addr;
            bank_wdata_d = req_wdata;
            drive_d      = req_we;
          end else begin
            // Out-of-range: skip the bank and respond immediately.
            state_d = S_RESP;
            if (gnt1) begin
              ack1_d = 1'b1;
              err1_d = 1'b1;
              if (!req_we) rdata1_d = '0;
            end else begin
              ack0_d = 1'b1;
              err0_d = 1'b1;
              if (!req_we) rdata0_d = '0;
            end
          end
        end
      end

      S_ACCESS: begin
        state_d = S_RESP;
        // Bank drives the bus during a read ACCESS; capture it on the
        // closing edge so it appears together with ack.
        if (sel_q) begin
          ack1_d = 1'b1;
          if (!we_q) rdata1_d = bank_data_io;
        end else begin
          ack0_d = 1'b1;
          if (!we_q) rdata0_d = bank_data_io;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      sel_q        <= 1'b0;
      we_q         <= 1'b0;
      bank_cs_q    <= 1'b0;
      bank_rd_wr_q <= 1'b1;
      bank_addr_q  <= '0;
      bank_wdata_q <= '0;
      drive_q      <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      bank_cs_q    <= bank_cs_d;
      bank_rd_wr_q <= bank_rd_wr_d;
      bank_addr_q  <= bank_addr_d;
      bank_wdata_q <= bank_wdata_d;
      drive_q      <= drive_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign ack0_o       = ack0_q;
  assign ack1_o       = ack1_q;
  assign err0_o       = err0_q;
  assign err1_o       = err1_q;
  assign rdata0_o     = rdata0_q;
  assign rdata1_o     = rdata1_q;
  assign bank_cs_o    = bank_cs_q;
  assign bank_rd_wr_o = bank_rd_wr_q;
  assign bank_addr_o  = bank_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_bank_arbiter.sv
// ============================================================================
// Module   : tb_reg_bank_arbiter
// Purpose  : Self-checking bench for reg_bank_arbiter (NUM_REG = 6) with a
//            behavioural register bank on the shared data bus and a
//            transaction-level scheduling model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_bank_arbiter;

  localparam int DW  = 8;
  localparam int AW  = 3;
  localparam int NREG = 6;

  logic          clk;
  logic          rst_n;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic          bank_cs, bank_rd_wr;
  logic [AW-1:0] bank_addr;
  wire  [DW-1:0] bank_data;

  int n_chk  = 0;
  int n_fail = 0;

  reg_bank_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_REG    (NREG)
  ) dut (
    .clk_i        (clk),
    .reset_ni     (rst_n),
    .req0_i       (req0),
    .req1_i       (req1),
    .we0_i        (we0),
    .we1_i        (we1),
    .addr0_i      (addr0),
    .addr1_i      (addr1),
    .wdata0_i     (wdata0),
    .wdata1_i     (wdata1),
    .ack0_o       (ack0),
    .ack1_o       (ack1),
    .err0_o       (err0),
    .err1_o       (err1),
    .rdata0_o     (rdata0),
    .rdata1_o     (rdata1),
    .bank_cs_o    (bank_cs),
    .bank_rd_wr_o (bank_rd_wr),
    .bank_addr_o  (bank_addr),
    .bank_data_io (bank_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural register bank ----------------
  logic [DW-1:0] bank_mem [2**AW];
  initial for (int i = 0; i < 2**AW; i++) bank_mem[i] = '0;
  assign bank_data = (bank_cs && bank_rd_wr) ? bank_mem[bank_addr] : {DW{1'bz}};
  always @(posedge clk) if (bank_cs && !bank_rd_wr) bank_mem[bank_addr] <= bank_data;

  // ---------------- transaction-level model ----------------
  // One transaction occupies the arbiter from its grant edge: a valid access
  // has its bank cycle right after the grant and its ack one cycle later; an
  // invalid access acks right after the grant. A new grant is possible three
  // (valid) or two (invalid) edges after the previous one.
  int            cyc = 0;
  int            next_free = 0;
  int            t_start = -100;
  bit            t_port = 1'b0, t_valid = 1'b0, t_we = 1'b0;
  logic [AW-1:0] t_addr = '0;
  logic [DW-1:0] t_wdata = '0;
  logic [DW-1:0] shadow [2**AW];
  logic [DW-1:0] m_rd [2];
  bit            m_last = 1'b1;
  bit            model_on = 1'b0;
  int            cs_cycles = 0;

  initial for (int i = 0; i < 2**AW; i++) shadow[i] = '0;

  always @(posedge clk) begin : model
    bit p;
    cyc++;
    if (!rst_n) begin
      model_on  = 1'b1;
      t_start   = -100;
      next_free = cyc + 1;
      m_last    = 1'b1;
      m_rd[0]   = '0;
      m_rd[1]   = '0;
    end else if (model_on) begin
      if (t_valid && cyc == t_start + 1) begin
        if (t_we) shadow[t_addr] = t_wdata;
        else      m_rd[t_port]   = shadow[t_addr];
      end
      if (cyc >= next_free && (req0 || req1)) begin
        p         = (req0 && req1) ? ~m_last : req1;
        m_last    = p;
        t_port    = p;
        t_we      = p ? we1 : we0;
        t_addr    = p ? addr1 : addr0;
        t_wdata   = p ? wdata1 : wdata0;
        t_valid   = (int'(t_addr) < NREG);
        t_start   = cyc;
        next_free = cyc + (t_valid ? 3 : 2);
        if (!t_valid && !t_we) m_rd[p] = '0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin : compare
    bit e_cs, e_ack0, e_ack1;
    if (bank_cs) cs_cycles++;
    if (model_on) begin
      e_cs   = t_valid && (cyc == t_start);
      e_ack0 = !t_port && (t_valid ? (cyc == t_start + 1) : (cyc == t_start));
      e_ack1 =  t_port && (t_valid ? (cyc == t_start + 1) : (cyc == t_start));
      chk("bank_cs", 32'(bank_cs), 32'(e_cs));
      chk("ack0", 32'(ack0), 32'(e_ack0));
      chk("ack1", 32'(ack1), 32'(e_ack1));
      chk("err0", 32'(err0), 32'(e_ack0 && !t_valid));
      chk("err1", 32'(err1), 32'(e_ack1 && !t_valid));
      chk("rdata0", 32'(rdata0), 32'(m_rd[0]));
      chk("rdata1", 32'(rdata1), 32'(m_rd[1]));
      chk("single_ack", 32'(ack0 && ack1), 32'd0);
      if (e_cs) begin
        chk("bank_rd_wr", 32'(bank_rd_wr), 32'(!t_we));
        chk("bank_addr", 32'(bank_addr), 32'(t_addr));
        if (t_we) chk("bank_wdata", 32'(bank_data), 32'(t_wdata));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input bit p, input bit v, input bit w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p) begin req1 = v; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = v; we0 = w; addr0 = a; wdata0 = d; end
  endtask

  // Called just after a negedge in an IDLE cycle; returns just after the
  // negedge of the following IDLE cycle.
  task automatic do_txn(input bit p, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int lat,
                        output logic [DW-1:0] rd, output logic er);
    set_req(p, 1'b1, w, a, d);
    lat = 0;
    rd  = 'x;
    er  = 'x;
    while (1) begin
      @(negedge clk);
      lat++;
      if (p ? ack1 : ack0) begin
        rd = p ? rdata1 : rdata0;
        er = p ? err1 : err0;
        break;
      end
      if (lat > 20) begin
        chk("txn_timeout", 32'(lat), 32'd2);
        break;
      end
    end
    set_req(p, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int            lat, t0, t1, nack, cs_before;
    logic [DW-1:0] rd;
    logic          er;
    int            order [6];
    int            exp_order [6];

    exp_order = '{0, 1, 0, 1, 0, 1};
    rst_n = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bank_cs", 32'(bank_cs), 32'd0);
    chk("rst_ack", 32'({ack0, ack1}), 32'd0);
    chk("rst_rdata", 32'({rdata0, rdata1}), 32'd0);
    chk("rst_rd_wr", 32'(bank_rd_wr), 32'd1);
    rst_n = 1'b1;

    // Contention from reset: port 0 wins first, port 1 three cycles later.
    set_req(0, 1'b1, 1'b1, 3'd1, 8'h11);
    set_req(1, 1'b1, 1'b1, 3'd2, 8'h22);
    t0 = -1; t1 = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ack0 && t0 < 0) begin t0 = c; set_req(0, 1'b0, 1'b0, '0, '0); end
      if (ack1) begin t1 = c; set_req(1, 1'b0, 1'b0, '0, '0); break; end
    end
    chk("cont_ack0_cycle", 32'(t0), 32'd2);
    chk("cont_ack1_cycle", 32'(t1), 32'd5);
    @(negedge clk);
    do_txn(0, 1'b0, 3'd1, 8'h00, lat, rd, er);
    chk("readback_addr1", 32'(rd), 32'h11);
    do_txn(1, 1'b0, 3'd2, 8'h00, lat, rd, er);
    chk("readback_addr2", 32'(rd), 32'h22);

    // Fairness: both ports keep requesting; last grant was port 1.
    set_req(0, 1'b1, 1'b0, 3'd1, 8'h00);
    set_req(1, 1'b1, 1'b0, 3'd2, 8'h00);
    nack = 0;
    for (int c = 0; c < 60 && nack < 6; c++) begin
      @(negedge clk);
      if (ack0) begin order[nack] = 0; nack++; end
      else if (ack1) begin order[nack] = 1; nack++; end
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    chk("fair_count", 32'(nack), 32'd6);
    for (int i = 0; i < 6; i++) chk("fair_order", 32'(order[i]), 32'(exp_order[i]));
    @(negedge clk);

    // Single port write then read.
    do_txn(0, 1'b1, 3'd3, 8'hA5, lat, rd, er);
    chk("wr_latency", 32'(lat), 32'd2);
    chk("wr_err", 32'(er), 32'd0);
    do_txn(0, 1'b0, 3'd3, 8'h00, lat, rd, er);
    chk("rd_latency", 32'(lat), 32'd2);
    chk("rd_data_a5", 32'(rd), 32'hA5);

    // Out of range on port 1 (NUM_REG = 6).
    do_txn(1, 1'b0, 3'd3, 8'h00, lat, rd, er);
    chk("p1_rd_a5", 32'(rd), 32'hA5);
    cs_before = cs_cycles;
    do_txn(1, 1'b0, 3'd7, 8'h00, lat, rd, er);
    chk("oor_latency", 32'(lat), 32'd1);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_rdata", 32'(rd), 32'd0);
    chk("oor_no_cs", 32'(cs_cycles), 32'(cs_before));
    do_txn(1, 1'b1, 3'd6, 8'h5A, lat, rd, er);
    chk("oor_wr_err", 32'(er), 32'd1);
    chk("oor_wr_no_cs", 32'(cs_cycles), 32'(cs_before));
    do_txn(0, 1'b0, 3'd5, 8'h00, lat, rd, er);
    chk("top_valid_err", 32'(er), 32'd0);

    // Reset during the ACCESS cycle of a port 0 read.
    set_req(0, 1'b1, 1'b0, 3'd3, 8'h00);
    @(negedge clk);
    chk("abort_in_access", 32'(bank_cs), 32'd1);
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("abort_no_ack", 32'(ack0), 32'd0);
    chk("abort_cs_low", 32'(bank_cs), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    do_txn(0, 1'b0, 3'd3, 8'h00, lat, rd, er);
    chk("reissue_latency", 32'(lat), 32'd2);
    chk("reissue_data", 32'(rd), 32'hA5);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
